layer_controller: RTL and testbench

- Sequences one fully-connected layer of M neurons. Each neuron has N inputs.
- Generalises the single-neuron controller to multiple neurons with a parametric terminal count.
- Adds an input-valid stall, per-neuron accumulator clear and result write strobes, and a ready/ack completion handshake.
- Sits between the top-level network FSM and the shared MAC datapath, weight/input memories and result register file.

---
 rtl/layer_ctrl_pkg.sv | 18 +
 rtl/layer_controller_if.sv | 44 ++++
 rtl/index_counter.sv | 38 +++
 rtl/layer_controller.sv | 146 ++++++++++++++
 tb/tb_layer_controller.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/layer_ctrl_pkg.sv
// Shared types and helpers for the fully-connected layer controller.
package layer_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StClear = 3'd1,
    StAccum = 3'd2,
    StBias  = 3'd3,
    StWrite = 3'd4,
    StDone  = 3'd5
  } state_e;

  // Counter width that stays at least one bit even for a single-value range.
  function automatic int unsigned clog2_min1(input int unsigned value);
    return (value <= 32'd1) ? 32'd1 : 32'($clog2(value));
  endfunction

endpackage

// File: rtl/layer_controller_if.sv
// Handshake and datapath-control bundle between the layer controller and its neighbours.
// LAYER_BIAS_EN adds the bias_ld strobe.
interface layer_controller_if
  import layer_ctrl_pkg::*;
#(
  parameter int unsigned N = 10,
  parameter int unsigned M = 4
);
  localparam int unsigned OFF_W = clog2_min1(N);
  localparam int unsigned IDX_W = clog2_min1(M);

  logic             start;
  logic             in_valid;
  logic             ack;
  logic [OFF_W-1:0] offset;
  logic [IDX_W-1:0] neuron_idx;
  logic             acc_clr;
  logic             ld;
  logic             wr;
  logic             busy;
  logic             ready;
`ifdef LAYER_BIAS_EN
  logic             bias_ld;

  modport master (
    input  start, in_valid, ack,
    output offset, neuron_idx, acc_clr, ld, wr, busy, ready, bias_ld
  );
  modport slave (
    output start, in_valid, ack,
    input  offset, neuron_idx, acc_clr, ld, wr, busy, ready, bias_ld
  );
`else
  modport master (
    input  start, in_valid, ack,
    output offset, neuron_idx, acc_clr, ld, wr, busy, ready
  );
  modport slave (
    output start, in_valid, ack,
    input  offset, neuron_idx, acc_clr, ld, wr, busy, ready
  );
`endif

endinterface

// File: rtl/index_counter.sv
// Saturating up-counter with synchronous init (priority over en) and terminal flag.
module index_counter #(
  parameter int unsigned MAX   = 0,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);

  logic [WIDTH-1:0] q_q, q_d;

  assign at_max = (q_q == MaxVal);
  assign q      = q_q;

  always_comb begin
    q_d = q_q;
    if (init) begin
      q_d = '0;
    end else if (en && !at_max) begin
      q_d = q_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/layer_controller.sv
// Sequences one fully-connected layer of M neurons x N inputs over a shared MAC.
// Define LAYER_BIAS_EN to insert a one-cycle bias-add state before each write.
module layer_controller
  import layer_ctrl_pkg::*;
#(
  parameter int unsigned N = 10,
  parameter int unsigned M = 4
) (
  input  logic               clk,
  input  logic               rst,
  layer_controller_if.master bus
);

  localparam int unsigned OFF_W = clog2_min1(N);
  localparam int unsigned IDX_W = clog2_min1(M);

  state_e           state_q;
  logic             acc_clr_q;
  logic             wr_q;
  logic             busy_q;
  logic             ready_q;
`ifdef LAYER_BIAS_EN
  logic             bias_ld_q;
`endif

  logic             off_init, off_en, off_at_max;
  logic             idx_init, idx_en, idx_at_max;
  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx;

  // Offset only moves in ACCUM; it is forced to 0 everywhere else and on the last input.
  always_comb begin
    off_en   = (state_q == StAccum) && bus.in_valid;
    off_init = (state_q != StAccum) || (bus.in_valid && off_at_max);
    idx_en   = (state_q == StWrite);
    case (state_q)
      StClear, StAccum, StBias: idx_init = 1'b0;
      StWrite:                  idx_init = idx_at_max;
      default:                  idx_init = 1'b1;
    endcase
  end

  index_counter #(
    .MAX   (N - 1),
    .WIDTH (OFF_W)
  ) u_offset_cnt (
    .clk    (clk),
    .rst    (rst),
    .init   (off_init),
    .en     (off_en),
    .q      (off),
    .at_max (off_at_max)
  );

  index_counter #(
    .MAX   (M - 1),
    .WIDTH (IDX_W)
  ) u_neuron_cnt (
    .clk    (clk),
    .rst    (rst),
    .init   (idx_init),
    .en     (idx_en),
    .q      (idx),
    .at_max (idx_at_max)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      acc_clr_q <= 1'b0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
`ifdef LAYER_BIAS_EN
      bias_ld_q <= 1'b0;
`endif
    end else begin
      acc_clr_q <= 1'b0;
      wr_q      <= 1'b0;
`ifdef LAYER_BIAS_EN
      bias_ld_q <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q   <= StClear;
            acc_clr_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        StClear: state_q <= StAccum;
        StAccum: begin
          if (bus.in_valid && off_at_max) begin
`ifdef LAYER_BIAS_EN
            state_q   <= StBias;
            bias_ld_q <= 1'b1;
`else
            state_q   <= StWrite;
            wr_q      <= 1'b1;
`endif
          end
        end
`ifdef LAYER_BIAS_EN
        StBias: begin
          state_q <= StWrite;
          wr_q    <= 1'b1;
        end
`endif
        StWrite: begin
          if (idx_at_max) begin
            state_q <= StDone;
            ready_q <= 1'b1;
          end else begin
            state_q   <= StClear;
            acc_clr_q <= 1'b1;
          end
        end
        StDone: begin
          if (bus.ack) begin
            state_q <= StIdle;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        // Unused encodings fall back to IDLE with all strobes low.
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.offset     = off;
  assign bus.neuron_idx = idx;
  assign bus.acc_clr    = acc_clr_q;
  assign bus.ld         = (state_q == StAccum) && bus.in_valid;
  assign bus.wr         = wr_q;
  assign bus.busy       = busy_q;
  assign bus.ready      = ready_q;
`ifdef LAYER_BIAS_EN
  assign bus.bias_ld    = bias_ld_q;
`endif

endmodule

// File: tb/tb_layer_controller.sv
// Self-checking bench for layer_controller: cycle tables and hand sequences on several
// parameterisations, with expected outputs queued at drive time and popped after the edge.
module tb_layer_controller;

  typedef struct {
    logic start, in_valid, ack;
    logic acc_clr, ld, wr, busy, ready;
    int   offset, idx;
    logic bias_ld;
  } vec_t;

  typedef logic [21:0] obs_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];
  vec_t tab_a[25];

  layer_controller_if #(.N(3), .M(2)) bus_a ();
  layer_controller_if #(.N(4), .M(1)) bus_b ();
  layer_controller_if #(.N(1), .M(1)) bus_c ();

  layer_controller #(.N(3), .M(2)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  layer_controller #(.N(4), .M(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  layer_controller #(.N(1), .M(1)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  logic bl_a, bl_b, bl_c;
`ifdef LAYER_BIAS_EN
  layer_controller_if #(.N(2), .M(2)) bus_d ();
  layer_controller #(.N(2), .M(2)) dut_d (.clk(clk), .rst(rst), .bus(bus_d));
  assign bl_a = bus_a.bias_ld;
  assign bl_b = bus_b.bias_ld;
  assign bl_c = bus_c.bias_ld;
`else
  assign bl_a = 1'b0;
  assign bl_b = 1'b0;
  assign bl_c = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic s, input logic v, input logic a, input logic clr,
                              input logic l, input logic w, input logic bsy, input logic rdy,
                              input int off, input int idx, input logic bld = 1'b0);
    vec_t r;
    r.start = s; r.in_valid = v; r.ack = a;
    r.acc_clr = clr; r.ld = l; r.wr = w; r.busy = bsy; r.ready = rdy;
    r.offset = off; r.idx = idx; r.bias_ld = bld;
    return r;
  endfunction

  function automatic obs_t pack(input vec_t v);
    logic [7:0] o8, i8;
    o8 = v.offset[7:0];
    i8 = v.idx[7:0];
    return {v.bias_ld, v.acc_clr, v.ld, v.wr, v.busy, v.ready, o8, i8};
  endfunction

  function automatic obs_t observe(input int sel);
    case (sel)
      0: return {bl_a, bus_a.acc_clr, bus_a.ld, bus_a.wr, bus_a.busy, bus_a.ready,
                 8'(bus_a.offset), 8'(bus_a.neuron_idx)};
      1: return {bl_b, bus_b.acc_clr, bus_b.ld, bus_b.wr, bus_b.busy, bus_b.ready,
                 8'(bus_b.offset), 8'(bus_b.neuron_idx)};
      2: return {bl_c, bus_c.acc_clr, bus_c.ld, bus_c.wr, bus_c.busy, bus_c.ready,
                 8'(bus_c.offset), 8'(bus_c.neuron_idx)};
`ifdef LAYER_BIAS_EN
      3: return {bus_d.bias_ld, bus_d.acc_clr, bus_d.ld, bus_d.wr, bus_d.busy, bus_d.ready,
                 8'(bus_d.offset), 8'(bus_d.neuron_idx)};
`endif
      default: return '0;
    endcase
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("bias_ld=%0b acc_clr=%0b ld=%0b wr=%0b busy=%0b ready=%0b off=%0d idx=%0d",
                     o[21], o[20], o[19], o[18], o[17], o[16], o[15:8], o[7:0]);
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %s | want %s", name, fmt(got), fmt(want));
    end
  endtask

  task automatic drive(input int sel, input logic s, input logic v, input logic a);
    bus_a.start = 1'b0; bus_a.in_valid = 1'b0; bus_a.ack = 1'b0;
    bus_b.start = 1'b0; bus_b.in_valid = 1'b0; bus_b.ack = 1'b0;
    bus_c.start = 1'b0; bus_c.in_valid = 1'b0; bus_c.ack = 1'b0;
`ifdef LAYER_BIAS_EN
    bus_d.start = 1'b0; bus_d.in_valid = 1'b0; bus_d.ack = 1'b0;
`endif
    case (sel)
      0: begin bus_a.start = s; bus_a.in_valid = v; bus_a.ack = a; end
      1: begin bus_b.start = s; bus_b.in_valid = v; bus_b.ack = a; end
      2: begin bus_c.start = s; bus_c.in_valid = v; bus_c.ack = a; end
`ifdef LAYER_BIAS_EN
      3: begin bus_d.start = s; bus_d.in_valid = v; bus_d.ack = a; end
`endif
      default: ;
    endcase
  endtask

  // Inputs go on at the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic step(input int sel, input vec_t v, input string name);
    @(negedge clk);
    drive(sel, v.start, v.in_valid, v.ack);
    exp_q.push_back(pack(v));
    @(posedge clk);
    #1;
    check(name, observe(sel), exp_q.pop_front());
  endtask

  initial begin
    //            s  v  a  clr ld wr bsy rdy off idx
    tab_a[0]  = mk(1, 1, 0, 1, 0, 0, 1, 0, 0, 0);
    tab_a[1]  = mk(0, 1, 0, 0, 1, 0, 1, 0, 0, 0);
    tab_a[2]  = mk(1, 1, 0, 0, 1, 0, 1, 0, 1, 0);  // start ignored in ACCUM
    tab_a[3]  = mk(0, 1, 0, 0, 1, 0, 1, 0, 2, 0);
    tab_a[4]  = mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    tab_a[5]  = mk(1, 1, 0, 1, 0, 0, 1, 0, 0, 1);  // start ignored in WRITE
    tab_a[6]  = mk(0, 1, 0, 0, 1, 0, 1, 0, 0, 1);
    tab_a[7]  = mk(0, 1, 0, 0, 1, 0, 1, 0, 1, 1);
    tab_a[8]  = mk(0, 1, 0, 0, 1, 0, 1, 0, 2, 1);
    tab_a[9]  = mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 1);
    tab_a[10] = mk(0, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    tab_a[11] = mk(0, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    tab_a[12] = mk(1, 1, 0, 0, 0, 0, 1, 1, 0, 0);  // start ignored in DONE
    tab_a[13] = mk(0, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    tab_a[14] = mk(0, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    tab_a[15] = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);  // ack: back to IDLE, start not taken
    tab_a[16] = mk(1, 1, 0, 1, 0, 0, 1, 0, 0, 0);  // held start launches next pass
    tab_a[17] = mk(0, 1, 0, 0, 1, 0, 1, 0, 0, 0);
    tab_a[18] = mk(0, 1, 0, 0, 1, 0, 1, 0, 1, 0);
    tab_a[19] = mk(0, 1, 0, 0, 1, 0, 1, 0, 2, 0);
    tab_a[20] = mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    tab_a[21] = mk(0, 1, 0, 1, 0, 0, 1, 0, 0, 1);
    tab_a[22] = mk(0, 1, 0, 0, 1, 0, 1, 0, 0, 1);
    tab_a[23] = mk(0, 1, 0, 0, 1, 0, 1, 0, 1, 1);
    tab_a[24] = mk(0, 1, 0, 0, 1, 0, 1, 0, 2, 1);

    rst = 1'b0;
    drive(-1, 1'b0, 1'b0, 1'b0);
    #2;
    check("reset A", observe(0), '0);
    check("reset B", observe(1), '0);
    check("reset C", observe(2), '0);
    @(negedge clk);
    rst = 1'b1;

`ifndef LAYER_BIAS_EN
    // N=3, M=2 full pass, handshake hold, restart, then reset mid-ACCUM at idx 1 / offset 2.
    for (int i = 0; i < 25; i++) step(0, tab_a[i], $sformatf("A cyc%0d", i + 1));
    #2 rst = 1'b0;
    #1 check("A async reset", observe(0), '0);
    @(negedge clk);
    rst = 1'b1;
    step(0, mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "A idle after reset 1");
    step(0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "A idle after reset 2");
    step(0, mk(1, 1, 0, 1, 0, 0, 1, 0, 0, 0), "A restart clear");
    step(0, mk(0, 1, 0, 0, 1, 0, 1, 0, 0, 0), "A restart neuron 0");

    // N=4, M=1 with a 3-cycle stall at offset 2.
    step(1, mk(1, 1, 0, 1, 0, 0, 1, 0, 0, 0), "B clear");
    step(1, mk(0, 1, 0, 0, 1, 0, 1, 0, 0, 0), "B off0");
    step(1, mk(0, 1, 0, 0, 1, 0, 1, 0, 1, 0), "B off1");
    step(1, mk(0, 1, 0, 0, 1, 0, 1, 0, 2, 0), "B off2");
    for (int i = 0; i < 3; i++) step(1, mk(0, 0, 0, 0, 0, 0, 1, 0, 2, 0), $sformatf("B stall%0d", i));
    step(1, mk(0, 1, 0, 0, 1, 0, 1, 0, 3, 0), "B off3");
    step(1, mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 0), "B write");
    step(1, mk(0, 1, 0, 0, 0, 0, 1, 1, 0, 0), "B done");
    step(1, mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0), "B ack");

    // N=1, M=1 boundary: ready after edge 4.
    step(2, mk(1, 1, 0, 1, 0, 0, 1, 0, 0, 0), "C clear");
    step(2, mk(0, 1, 0, 0, 1, 0, 1, 0, 0, 0), "C accum");
    step(2, mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 0), "C write");
    step(2, mk(0, 1, 0, 0, 0, 0, 1, 1, 0, 0), "C done");
    step(2, mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0), "C ack");
`else
    // N=2, M=2 with bias: bias_ld one cycle before each wr, not stallable, ready after edge 11.
    step(3, mk(1, 1, 0, 1, 0, 0, 1, 0, 0, 0), "D clear0");
    step(3, mk(0, 1, 0, 0, 1, 0, 1, 0, 0, 0), "D off0");
    step(3, mk(0, 1, 0, 0, 1, 0, 1, 0, 1, 0), "D off1");
    step(3, mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1'b1), "D bias0");
    step(3, mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0), "D write0");
    step(3, mk(0, 1, 0, 1, 0, 0, 1, 0, 0, 1), "D clear1");
    step(3, mk(0, 1, 0, 0, 1, 0, 1, 0, 0, 1), "D off0 n1");
    step(3, mk(0, 1, 0, 0, 1, 0, 1, 0, 1, 1), "D off1 n1");
    step(3, mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 1'b1), "D bias1");
    step(3, mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 1), "D write1");
    step(3, mk(0, 1, 0, 0, 0, 0, 1, 1, 0, 0), "D done");
    step(3, mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0), "D ack");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
